// File: rtl/cdb_pkg.sv
// Shared types and constants for the CDB writeback stage.
package cdb_pkg;

    localparam int CDB_DATA_W = 32;
    localparam int CDB_TAG_W  = 6;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LS  = 1'b1;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_result_t;

endpackage

// File: rtl/cdb_writeback_if.sv
// Result-producer handshakes and CDB broadcast bundle for cdb_writeback.
interface cdb_writeback_if
    import cdb_pkg::*;
#(
    parameter int DATA_W = CDB_DATA_W,
    parameter int TAG_W  = CDB_TAG_W
);
    logic              alu_valid;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              ls_valid;
    logic [TAG_W-1:0]  ls_tag;
    logic [DATA_W-1:0] ls_data;
    logic              ls_ready;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_src;

    modport master (
        output alu_valid, alu_tag, alu_data,
        output ls_valid, ls_tag, ls_data,
        input  alu_ready, ls_ready,
        input  cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  alu_valid, alu_tag, alu_data,
        input  ls_valid, ls_tag, ls_data,
        output alu_ready, ls_ready,
        output cdb_valid, cdb_tag, cdb_data, cdb_src
    );

endinterface

// File: rtl/wb_fifo.sv
// Small circular-buffer FIFO holding completed results for one execution unit.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             ready,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Ready looks only at occupancy, so a full FIFO stays unready even while popping.
    assign ready      = count_q < CNT_W'(DEPTH);
    assign head_valid = count_q != '0;
    assign head_data  = mem_q[rd_ptr_q];
    assign do_push    = push_valid && ready;
    assign do_pop     = pop && head_valid;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cdb_writeback.sv
// Merges ALU and load/store results onto a registered common data bus,
// one result per cycle, alternating priority under contention.
module cdb_writeback
    import cdb_pkg::*;
#(
    parameter int DATA_W = CDB_DATA_W,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DEPTH  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    cdb_writeback_if.slave  bus
);
    localparam int ENT_W = TAG_W + DATA_W;

    logic [ENT_W-1:0]  alu_head;
    logic [ENT_W-1:0]  ls_head;
    logic              alu_ne;
    logic              ls_ne;
    logic              alu_pop;
    logic              ls_pop;

    logic              prio_q, prio_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic              cdb_src_q, cdb_src_d;

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_alu_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (bus.alu_valid),
        .push_data  ({bus.alu_tag, bus.alu_data}),
        .ready      (bus.alu_ready),
        .pop        (alu_pop),
        .head_valid (alu_ne),
        .head_data  (alu_head)
    );

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_ls_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (bus.ls_valid),
        .push_data  ({bus.ls_tag, bus.ls_data}),
        .ready      (bus.ls_ready),
        .pop        (ls_pop),
        .head_valid (ls_ne),
        .head_data  (ls_head)
    );

    // prio=0 favours the ALU; it only flips on cycles where both heads compete.
    assign alu_pop = alu_ne && (!ls_ne || !prio_q);
    assign ls_pop  = ls_ne && (!alu_ne || prio_q);

    always_comb begin
        prio_d      = prio_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (flush) begin
            prio_d = 1'b0;
        end else begin
            if (alu_ne && ls_ne) begin
                prio_d = !prio_q;
            end
            if (alu_pop) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = alu_head[ENT_W-1:DATA_W];
                cdb_data_d  = alu_head[DATA_W-1:0];
                cdb_src_d   = SRC_ALU;
            end else if (ls_pop) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = ls_head[ENT_W-1:DATA_W];
                cdb_data_d  = ls_head[DATA_W-1:0];
                cdb_src_d   = SRC_LS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= 1'b0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= SRC_ALU;
        end else begin
            prio_q      <= prio_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_writeback.sv
// Bench for cdb_writeback: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdb_writeback;
    import cdb_pkg::*;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    cdb_writeback_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    cdb_writeback #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // Reference model: two result queues, a priority bit and the broadcast register.
    cdb_result_t m_alu[$];
    cdb_result_t m_ls[$];
    bit          m_prio;
    bit          m_valid;
    logic [5:0]  m_tag;
    logic [31:0] m_data;
    bit          m_src;
    bit          acc_a;
    bit          acc_l;

    typedef struct {
        bit         src;
        logic [5:0] tag;
        int         cyc;
    } ev_t;
    ev_t log_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    cdb_result_t pa[$];
    cdb_result_t pl[$];

    function automatic cdb_result_t mk(int tag, logic [31:0] data);
        cdb_result_t r;
        r.tag  = 6'(tag);
        r.data = data;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(bit r, bit f, bit av, cdb_result_t ar, bit lv, cdb_result_t lr);
        int take;
        cdb_result_t e;
        acc_a = 0;
        acc_l = 0;
        if (r) begin
            m_alu.delete(); m_ls.delete();
            m_prio = 0; m_valid = 0; m_tag = 0; m_data = 0; m_src = 0;
            return;
        end
        if (f) begin
            m_alu.delete(); m_ls.delete();
            m_prio = 0; m_valid = 0;
            return;
        end
        acc_a = av && (m_alu.size() < DEPTH);
        acc_l = lv && (m_ls.size() < DEPTH);
        take = -1;
        if (m_alu.size() > 0 && m_ls.size() > 0) begin
            take   = m_prio ? 1 : 0;
            m_prio = !m_prio;
        end else if (m_alu.size() > 0) begin
            take = 0;
        end else if (m_ls.size() > 0) begin
            take = 1;
        end
        m_valid = (take >= 0);
        if (take == 0) begin
            e = m_alu.pop_front();
            m_tag = e.tag; m_data = e.data; m_src = 0;
        end else if (take == 1) begin
            e = m_ls.pop_front();
            m_tag = e.tag; m_data = e.data; m_src = 1;
        end
        if (acc_a) m_alu.push_back(ar);
        if (acc_l) m_ls.push_back(lr);
    endtask

    task automatic cycle(bit r, bit f, bit av, cdb_result_t ar, bit lv, cdb_result_t lr);
        ev_t ev;
        rst = r;
        flush = f;
        bus.alu_valid = av; bus.alu_tag = ar.tag; bus.alu_data = ar.data;
        bus.ls_valid  = lv; bus.ls_tag  = lr.tag; bus.ls_data  = lr.data;
        model_step(r, f, av, ar, lv, lr);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("alu_ready", 64'(bus.alu_ready), 64'(m_alu.size() < DEPTH));
        chk("ls_ready",  64'(bus.ls_ready),  64'(m_ls.size() < DEPTH));
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
        chk("cdb_tag",   64'(bus.cdb_tag),   64'(m_tag));
        chk("cdb_data",  64'(bus.cdb_data),  64'(m_data));
        chk("cdb_src",   64'(bus.cdb_src),   64'(m_src));
        if (bus.cdb_valid === 1'b1) begin
            ev.src = bus.cdb_src;
            ev.tag = bus.cdb_tag;
            ev.cyc = cyc;
            log_q.push_back(ev);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, '0);
    endtask

    // Presents the pending lists as well-behaved producers until both drain.
    task automatic run_pending(int max_cycles);
        cdb_result_t ar, lr;
        for (int i = 0; i < max_cycles && (pa.size() > 0 || pl.size() > 0); i++) begin
            ar = '0; lr = '0;
            if (pa.size() > 0) ar = pa[0];
            if (pl.size() > 0) lr = pl[0];
            cycle(0, 0, pa.size() > 0, ar, pl.size() > 0, lr);
            if (acc_a) void'(pa.pop_front());
            if (acc_l) void'(pl.pop_front());
        end
        chk("pending_drained", 64'(pa.size() + pl.size()), 64'd0);
    endtask

    initial begin
        int exp_tag[6];
        int exp_src[6];
        int n_ls_acc;
        int k;
        bit hold_a, hold_l, av, lv, r, f;
        cdb_result_t ar, lr;

        rst = 1; flush = 0;
        bus.alu_valid = 0; bus.alu_tag = '0; bus.alu_data = '0;
        bus.ls_valid  = 0; bus.ls_tag  = '0; bus.ls_data  = '0;
        cycle(1, 0, 0, '0, 0, '0);
        cycle(1, 0, 0, '0, 0, '0);
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_cdb_tag",   64'(bus.cdb_tag),   64'd0);
        chk("rst_cdb_data",  64'(bus.cdb_data),  64'd0);
        cycle(0, 0, 0, '0, 0, '0);
        chk("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("rst_ls_ready",  64'(bus.ls_ready),  64'd1);

        // Single ALU result: broadcast on the second edge, for one cycle.
        cycle(0, 0, 1, mk(5, 32'hDEAD_BEEF), 0, '0);
        chk("single_not_yet", 64'(bus.cdb_valid), 64'd0);
        cycle(0, 0, 0, '0, 0, '0);
        chk("single_valid", 64'(bus.cdb_valid), 64'd1);
        chk("single_tag",   64'(bus.cdb_tag),   64'd5);
        chk("single_data",  64'(bus.cdb_data),  64'hDEAD_BEEF);
        chk("single_src",   64'(bus.cdb_src),   64'd0);
        cycle(0, 0, 0, '0, 0, '0);
        chk("single_one_cycle", 64'(bus.cdb_valid), 64'd0);

        // Contention alternation.
        log_q.delete();
        for (int i = 0; i < 3; i++) begin
            pa.push_back(mk(1 + i, $urandom));
            pl.push_back(mk(9 + i, $urandom));
        end
        run_pending(20);
        idle(4);
        exp_tag = '{1, 9, 2, 10, 3, 11};
        exp_src = '{0, 1, 0, 1, 0, 1};
        chk("alt_count", 64'(log_q.size()), 64'd6);
        if (log_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("alt_tag", 64'(log_q[i].tag), 64'(exp_tag[i]));
                chk("alt_src", 64'(log_q[i].src), 64'(exp_src[i]));
            end
            chk("alt_no_gap", 64'(log_q[5].cyc - log_q[0].cyc), 64'd5);
        end

        // Backpressure: flush first so prio starts at 0.
        cycle(0, 1, 0, '0, 0, '0);
        log_q.delete();
        for (int i = 0; i < 6; i++) pa.push_back(mk(40 + i, $urandom));
        for (int i = 0; i < 3; i++) pl.push_back(mk(50 + i, $urandom));
        n_ls_acc = 0;
        k = 0;
        while ((pa.size() > 0 || pl.size() > 0) && k < 40) begin
            ar = '0; lr = '0;
            if (pa.size() > 0) ar = pa[0];
            if (pl.size() > 0) lr = pl[0];
            cycle(0, 0, pa.size() > 0, ar, pl.size() > 0, lr);
            if (n_ls_acc == 2 && k == 2) chk("full_pop_ready_back", 64'(bus.ls_ready), 64'd1);
            if (acc_a) void'(pa.pop_front());
            if (acc_l) begin
                void'(pl.pop_front());
                n_ls_acc++;
                if (n_ls_acc == 2) chk("bp_ls_ready_low", 64'(bus.ls_ready), 64'd0);
            end
            k++;
        end
        idle(6);
        begin
            int ls_seen[$];
            int alu_seen[$];
            foreach (log_q[i]) begin
                if (log_q[i].src) ls_seen.push_back(int'(log_q[i].tag));
                else alu_seen.push_back(int'(log_q[i].tag));
            end
            chk("bp_ls_count", 64'(ls_seen.size()), 64'd3);
            chk("bp_alu_count", 64'(alu_seen.size()), 64'd6);
            for (int i = 0; i < 3 && i < ls_seen.size(); i++) chk("bp_ls_order", 64'(ls_seen[i]), 64'(50 + i));
            for (int i = 0; i < 6 && i < alu_seen.size(); i++) chk("bp_alu_order", 64'(alu_seen[i]), 64'(40 + i));
        end

        // Flush mid-stream with an ALU push on the flush edge.
        log_q.delete();
        cycle(0, 0, 1, mk(20, $urandom), 1, mk(30, $urandom));
        cycle(0, 0, 1, mk(21, $urandom), 1, mk(31, $urandom));
        cycle(0, 1, 1, mk(22, $urandom), 0, '0);
        chk("flush_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("flush_alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("flush_ls_ready",  64'(bus.ls_ready),  64'd1);
        idle(4);
        cycle(0, 0, 1, mk(23, $urandom), 1, mk(33, $urandom));
        idle(4);
        chk("flush_log_count", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            chk("flush_pre_tag", 64'(log_q[0].tag), 64'd20);
            chk("flush_first_after", 64'(log_q[1].tag), 64'd23);
            chk("flush_first_src", 64'(log_q[1].src), 64'd0);
            chk("flush_second_after", 64'(log_q[2].tag), 64'd33);
        end

        // Reset mid-operation.
        cycle(0, 0, 1, mk(60, $urandom), 1, mk(61, $urandom));
        cycle(0, 0, 1, mk(62, $urandom), 1, mk(63, $urandom));
        chk("pre_rst_valid", 64'(bus.cdb_valid), 64'd1);
        log_q.delete();
        cycle(1, 0, 1, mk(2, $urandom), 1, mk(3, $urandom));
        chk("midrst_valid", 64'(bus.cdb_valid), 64'd0);
        chk("midrst_tag",   64'(bus.cdb_tag),   64'd0);
        chk("midrst_data",  64'(bus.cdb_data),  64'd0);
        chk("midrst_src",   64'(bus.cdb_src),   64'd0);
        cycle(0, 0, 0, '0, 0, '0);
        chk("midrst_alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("midrst_ls_ready",  64'(bus.ls_ready),  64'd1);
        idle(4);
        chk("midrst_no_stale", 64'(log_q.size()), 64'd0);

        // Randomized traffic; producers hold their offer until accepted.
        hold_a = 0; hold_l = 0;
        ar = '0; lr = '0;
        av = 0; lv = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold_a) begin
                av = ($urandom_range(0, 99) < 65);
                ar = mk($urandom_range(0, 63), $urandom);
            end
            if (!hold_l) begin
                lv = ($urandom_range(0, 99) < 55);
                lr = mk($urandom_range(0, 63), $urandom);
            end
            r = ($urandom_range(0, 499) == 0);
            f = ($urandom_range(0, 99) == 0);
            cycle(r, f, av, ar, lv, lr);
            hold_a = av && !acc_a && !r && !f;
            hold_l = lv && !acc_l && !r && !f;
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
